rv32i_mc_control_unit: RTL
==========================

Name: rv32i_mc_control_unit

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory access and write-back for each instruction.
- Drives the 3-bit write-back select that chooses the register-file write data (ALU, load data, immediate, PC+imm, PC+4), plus all PC, IR, register-file and data-memory enables.
- Handles the data-memory ready handshake, with a timeout trap and an illegal-opcode trap.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in MEM with dmem_ready low before a memory-fault trap; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_code  in  32  instruction word from instruction memory, valid in FETCH.
- branch_taken  in  1  comparator result for the current branch, valid in EXECUTE.
- dmem_ready  in  1  data-memory completion handshake.
- ir_en  out  1  instruction register load.
- pc_en  out  1  PC register load.
- pc_src_sel  out  2  next-PC source: 00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared.
- reg_wr_en  out  1  register-file write enable.
- rf_wd_sel  out  3  write-back select: 000 ALU, 001 load data, 010 imm (LUI), 011 PC+imm (AUIPC), 100 PC+4 (JAL/JALR).
- alu_src_sel  out  1  ALU operand B source: 0 rs2, 1 immediate.
- alu_control  out  4  ALU operation code.
- dmem_req  out  1  data-memory request.
- dmem_wr_en  out  1  data-memory write (store).
- dmem_size  out  3  access type, equal to IR funct3.
- instr_retired  out  1  one-cycle pulse in the last cycle of every completed instruction.
- illegal_instr  out  1  sticky illegal-opcode flag.
- mem_fault  out  1  sticky memory-timeout flag.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Internal registers: state, 32-bit IR copy, wait counter.
- Reset (asynchronous, active-low):
  - state=FETCH; IR copy=0; counter=0; illegal_instr=0; mem_fault=0.
  - While reset is low, every enable/pulse output is 0, rf_wd_sel=000, pc_src_sel=00, alu_control=0000.
  - Reset mid-instruction aborts it with no partial writes after the assertion edge.
- FETCH: ir_en=1, and the IR copy captures instr_code. Next state DECODE.
- DECODE: classify the opcode.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR. Next state EXECUTE.
  - Any other opcode -> TRAP, with illegal_instr set on entry.
- EXECUTE:
  - alu_src_sel=0 for R and BRANCH; 1 otherwise.
  - alu_control = {funct7[5], funct3} for R; for I: {funct7[5], funct3} when funct3=101, else {0, funct3}; 0000 (ADD) for LOAD, STORE, JALR, AUIPC, LUI, JAL.
  - BRANCH: pc_en=1; pc_src_sel=01 if branch_taken, else 00; instr_retired=1; next state FETCH (3 cycles total).
  - LOAD/STORE -> MEM, counter cleared. All other classes -> WB.
- MEM:
  - dmem_req=1 and dmem_wr_en=(STORE) held constant until dmem_ready is sampled 1. The counter increments each waiting cycle.
  - On dmem_ready=1: LOAD -> WB; STORE -> pc_en=1, pc_src_sel=00, instr_retired=1, next state FETCH.
  - If MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX with dmem_ready still 0 -> TRAP with mem_fault=1.
  - dmem_ready outside MEM is ignored.
- WB: reg_wr_en=1 and instr_retired=1; next state FETCH.
  - rf_wd_sel is 000 for R/I, 001 for LOAD, 010 for LUI, 011 for AUIPC, 100 for JAL/JALR.
  - pc_en=1 with pc_src_sel 01 for JAL, 10 for JALR, 00 otherwise. The PC+4 write-back and the PC load use the pre-update PC in the same cycle.
- rf_wd_sel is never 101–111. It is 000 in every state except WB.
- The decoder does not inspect rd: a write with rd=x0 is still asserted, and the register file discards it.
- TRAP: absorbing state. All enables are 0 and flags are held until reset.
- Cycle counts:
  - R, I, LUI, AUIPC, JAL, JALR: 4.
  - BRANCH: 3.
  - LOAD: 5 + wait cycles.
  - STORE: 4 + wait cycles.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with dmem_ready tied 1 -> FETCH/DECODE/EXECUTE/WB. In WB: reg_wr_en=1, rf_wd_sel=000, alu_control=0000, pc_src_sel=00, instr_retired=1. Next fetch on cycle 5.
- LW x5,4(x1) (0x0040A283) with dmem_ready low for 3 MEM cycles -> dmem_req held 4 cycles with dmem_wr_en=0 and dmem_size=010. Then WB with rf_wd_sel=001; 8 cycles total.
- BEQ with branch_taken=1, then again with 0 -> pc_en=1 in EXECUTE, pc_src_sel=01 then 00. reg_wr_en stays 0 both times; 3 cycles each.
- Sequence LUI, AUIPC, JAL, JALR -> WB rf_wd_sel=010, 011, 100, 100. pc_src_sel=00, 00, 01, 10.
- SW with dmem_ready stuck 0 and MEM_WAIT_MAX=15 -> after 15 MEM cycles, TRAP with mem_fault=1 and all enables 0. Release reset: back to FETCH with flags cleared.
- Opcode 0x7F, then reset asserted in the middle of a LOAD MEM wait -> illegal_instr=1 and TRAP held indefinitely. For the mid-load reset: dmem_req drops asynchronously, and no reg_wr_en pulse follows.

Source files
------------

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with illegal-opcode
// and data-memory timeout traps. Outputs are decoded from state and the IR copy.
module rv32i_mc_control_unit #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_src_sel,
  output logic        reg_wr_en,
  output logic [2:0]  rf_wd_sel,
  output logic        alu_src_sel,
  output logic [3:0]  alu_control,
  output logic        dmem_req,
  output logic        dmem_wr_en,
  output logic [2:0]  dmem_size,
  output logic        instr_retired,
  output logic        illegal_instr,
  output logic        mem_fault
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t          state_reg;
  logic [31:0]     ir_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic            illegal_reg;
  logic            fault_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_r, is_i, is_load, is_store, is_branch;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_legal;
  logic [3:0] alu_op;
  logic [2:0] wb_sel;
  logic       unused_ir;

  assign opcode    = ir_reg[6:0];
  assign funct3    = ir_reg[14:12];
  assign funct7_b5 = ir_reg[30];
  // Register fields are consumed by the datapath, not by this controller.
  assign unused_ir = ^{ir_reg[31], ir_reg[29:15], ir_reg[11:7]};

  assign is_r      = (opcode == 7'b0110011);
  assign is_i      = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                     is_lui | is_auipc | is_jal | is_jalr;

  // Shift-immediates carry the arithmetic/logical selector in funct7[5]; other
  // I-type ops have immediate bits there, so it is masked off.
  always_comb begin
    alu_op = 4'b0000;
    if (is_r)
      alu_op = {funct7_b5, funct3};
    else if (is_i)
      alu_op = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
  end

  always_comb begin
    wb_sel = 3'b000;
    if (is_load)               wb_sel = 3'b001;
    else if (is_lui)           wb_sel = 3'b010;
    else if (is_auipc)         wb_sel = 3'b011;
    else if (is_jal | is_jalr) wb_sel = 3'b100;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_FETCH;
      ir_reg       <= 32'd0;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          ir_reg    <= instr_code;
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          if (is_legal) begin
            state_reg <= S_EXECUTE;
          end else begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (is_branch) begin
            state_reg <= S_FETCH;
          end else if (is_load | is_store) begin
            state_reg    <= S_MEM;
            wait_cnt_reg <= '0;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_reg <= is_load ? S_WB : S_FETCH;
          end else if (MEM_WAIT_MAX != 0 && wait_cnt_reg == CW'(MEM_WAIT_MAX - 1)) begin
            state_reg <= S_TRAP;
            fault_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Gating with reset makes every enable drop the moment reset asserts.
  always_comb begin
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_src_sel    = 2'b00;
    reg_wr_en     = 1'b0;
    rf_wd_sel     = 3'b000;
    alu_src_sel   = 1'b0;
    alu_control   = 4'b0000;
    dmem_req      = 1'b0;
    dmem_wr_en    = 1'b0;
    instr_retired = 1'b0;
    dmem_size     = funct3;
    if (reset) begin
      if (state_reg == S_EXECUTE || state_reg == S_MEM || state_reg == S_WB) begin
        alu_src_sel = ~(is_r | is_branch);
        alu_control = alu_op;
      end
      case (state_reg)
        S_FETCH: ir_en = 1'b1;
        S_EXECUTE: begin
          if (is_branch) begin
            pc_en         = 1'b1;
            pc_src_sel    = branch_taken ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req   = 1'b1;
          dmem_wr_en = is_store;
          if (dmem_ready && is_store) begin
            pc_en         = 1'b1;
            instr_retired = 1'b1;
          end
        end
        S_WB: begin
          reg_wr_en     = 1'b1;
          instr_retired = 1'b1;
          pc_en         = 1'b1;
          rf_wd_sel     = wb_sel;
          pc_src_sel    = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = illegal_reg;
  assign mem_fault     = fault_reg;

endmodule
